pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    // Controller state: normal issue, second cycle of a 2-cycle stall, multiply hold.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    // Operand-use codes of the instruction sitting in ID.
    localparam logic [1:0] FWD_NONE  = 2'b00;  // no register sources
    localparam logic [1:0] FWD_STUR  = 2'b01;  // Rn only
    localparam logic [1:0] FWD_ITYPE = 2'b10;  // Rn only
    localparam logic [1:0] FWD_RTYPE = 2'b11;  // Rn and Rm

    // Zero register: never produced by an instruction, so never a hazard.
    localparam logic [4:0] XZR = 5'd31;

    localparam int MUL_LAT_DEFAULT = 4;
    localparam int CNT_W           = 3;

    // True when source register r depends on the EX destination.
    function automatic logic reg_hazard(input logic [4:0] r, input logic [4:0] tgt);
        return (r != XZR) && (r == tgt);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use / CBZ dependency check against the EX instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [1:0] fwdEn_ID,
    input  logic [4:0] Rn_ID,
    input  logic [4:0] Rm_ID,
    input  logic [4:0] Rt_ID,
    input  logic       isCBZ_ID,
    input  logic       MemRead_EX,
    input  logic       RegWrite_EX,
    input  logic [4:0] targetReg_EX,
    output logic       o_stall_req,
    output logic [1:0] o_stall_len
);

    logic w_rn_used;
    logic w_rm_used;
    logic w_load_use;
    logic w_cbz_dep;

    assign w_rn_used  = (fwdEn_ID != FWD_NONE);
    assign w_rm_used  = (fwdEn_ID == FWD_RTYPE);

    // A load result is only available after MEM, so a dependent ID instruction waits one cycle.
    assign w_load_use = MemRead_EX &&
                        ((w_rn_used && reg_hazard(Rn_ID, targetReg_EX)) ||
                         (w_rm_used && reg_hazard(Rm_ID, targetReg_EX)));

    // CBZ resolves in ID, so it must wait for any in-flight producer of its test register.
    assign w_cbz_dep  = isCBZ_ID && RegWrite_EX && reg_hazard(Rt_ID, targetReg_EX);

    // Stall length: CBZ behind a load needs two cycles, every other dependency one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        o_stall_len = 2'd0;
        if (w_cbz_dep && MemRead_EX)
            o_stall_len = 2'd2;
        else if (w_cbz_dep || w_load_use)
            o_stall_len = 2'd1;
    end

    assign o_stall_req = (o_stall_len != 2'd0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/freeze/flush controller: FSM, hold counter and output decode.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] fwdEn_ID,
    input  logic [4:0] Rn_ID,
    input  logic [4:0] Rm_ID,
    input  logic [4:0] Rt_ID,
    input  logic       isCBZ_ID,
    input  logic       branchTaken_ID,
    input  logic       MemRead_EX,
    input  logic       RegWrite_EX,
    input  logic [4:0] targetReg_EX,
    input  logic       mulStart_EX,
    output logic       PCWrite,
    output logic       IFID_en,
    output logic       IDEX_bubble,
    output logic       EXMEM_bubble,
    output logic       IFID_flush,
    output logic       mul_busy
);

    // Counter preload at multiply start: the start cycle itself is the first freeze cycle.
    localparam logic [CNT_W-1:0] MUL_PRELOAD = CNT_W'(MUL_LAT - 2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stall_req;
    logic [1:0]       w_stall_len;

    hazard_detect u_hazard_detect (
        .fwdEn_ID     (fwdEn_ID),
        .Rn_ID        (Rn_ID),
        .Rm_ID        (Rm_ID),
        .Rt_ID        (Rt_ID),
        .isCBZ_ID     (isCBZ_ID),
        .MemRead_EX   (MemRead_EX),
        .RegWrite_EX  (RegWrite_EX),
        .targetReg_EX (targetReg_EX),
        .o_stall_req  (w_stall_req),
        .o_stall_len  (w_stall_len)
    );

    // State and counter update; reset aborts any stall or multiply sequence.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mulStart_EX) begin
                        r_state <= ST_MUL;
                        r_cnt   <= MUL_PRELOAD;
                    end else if (w_stall_len == 2'd2) begin
                        r_state <= ST_STALL;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_STALL: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
                ST_MUL: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - CNT_W'(1);
                    else
                        r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode: stall and freeze act in the cycle they are detected, so outputs are combinational.
    always_comb begin
        PCWrite      = 1'b1;
        IFID_en      = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_bubble = 1'b0;
        IFID_flush   = 1'b0;
        mul_busy     = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (mulStart_EX) begin
                        PCWrite      = 1'b0;
                        IFID_en      = 1'b0;
                        EXMEM_bubble = 1'b1;
                        mul_busy     = 1'b1;
                    end else if (w_stall_req) begin
                        PCWrite     = 1'b0;
                        IFID_en     = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else if (branchTaken_ID) begin
                        IFID_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    PCWrite     = 1'b0;
                    IFID_en     = 1'b0;
                    IDEX_bubble = 1'b1;
                end
                ST_MUL: begin
                    if (r_cnt != '0) begin
                        PCWrite      = 1'b0;
                        IFID_en      = 1'b0;
                        EXMEM_bubble = 1'b1;
                        mul_busy     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver queues hand-computed expectations,
// a monitor compares them against two instances (MUL_LAT=4 and MUL_LAT=2).
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    // Output vector order: {PCWrite, IFID_en, IDEX_bubble, EXMEM_bubble, IFID_flush, mul_busy}
    localparam logic [5:0] DEF = 6'b110000;
    localparam logic [5:0] STL = 6'b001000;
    localparam logic [5:0] FRZ = 6'b000101;
    localparam logic [5:0] FLU = 6'b110010;

    typedef struct {
        string      name;
        logic [5:0] exp_a;
        logic [5:0] exp_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] fwdEn_ID = FWD_NONE;
    logic [4:0] Rn_ID = '0, Rm_ID = '0, Rt_ID = '0, targetReg_EX = '0;
    logic       isCBZ_ID = 1'b0, branchTaken_ID = 1'b0;
    logic       MemRead_EX = 1'b0, RegWrite_EX = 1'b0, mulStart_EX = 1'b0;

    logic [5:0] out_a, out_b;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MUL_LAT(4)) dut_a (
        .clk(clk), .reset(reset), .fwdEn_ID(fwdEn_ID),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .Rt_ID(Rt_ID),
        .isCBZ_ID(isCBZ_ID), .branchTaken_ID(branchTaken_ID),
        .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
        .targetReg_EX(targetReg_EX), .mulStart_EX(mulStart_EX),
        .PCWrite(out_a[5]), .IFID_en(out_a[4]), .IDEX_bubble(out_a[3]),
        .EXMEM_bubble(out_a[2]), .IFID_flush(out_a[1]), .mul_busy(out_a[0])
    );

    pipeline_ctrl #(.MUL_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .fwdEn_ID(fwdEn_ID),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .Rt_ID(Rt_ID),
        .isCBZ_ID(isCBZ_ID), .branchTaken_ID(branchTaken_ID),
        .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
        .targetReg_EX(targetReg_EX), .mulStart_EX(mulStart_EX),
        .PCWrite(out_b[5]), .IFID_en(out_b[4]), .IDEX_bubble(out_b[3]),
        .EXMEM_bubble(out_b[2]), .IFID_flush(out_b[1]), .mul_busy(out_b[0])
    );

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
    task automatic drv(input string nm, input logic rst, input logic mul, input logic br,
                       input logic mr, input logic rw, input logic cbz, input logic [1:0] fwd,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt,
                       input logic [4:0] tgt, input logic [5:0] ea, input logic [5:0] eb);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; mulStart_EX = mul; branchTaken_ID = br;
        MemRead_EX = mr; RegWrite_EX = rw; isCBZ_ID = cbz; fwdEn_ID = fwd;
        Rn_ID = rn; Rm_ID = rm; Rt_ID = rt; targetReg_EX = tgt;
        e.name = nm; e.exp_a = ea; e.exp_b = eb;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [5:0] ea, input logic [5:0] eb);
        drv(nm, 0, 0, 0, 0, 0, 0, FWD_NONE, 0, 0, 0, 0, ea, eb);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, "/lat4"}, out_a, e.exp_a);
            check({e.name, "/lat2"}, out_b, e.exp_b);
        end
    end

    initial begin
        // Reset dominates every other input.
        drv("rst_garbage1", 1, 1, 1, 1, 1, 1, FWD_RTYPE, 5, 5, 5, 5, DEF, DEF);
        drv("rst_garbage2", 1, 1, 1, 1, 1, 1, FWD_RTYPE, 5, 5, 5, 5, DEF, DEF);
        idle("idle_run", DEF, DEF);

        // Load-use on Rm, then bubble has cleared the load.
        drv("loaduse_rm", 0, 0, 0, 1, 1, 0, FWD_RTYPE, 3, 5, 0, 5, STL, STL);
        idle("loaduse_after", DEF, DEF);
        drv("xzr_no_stall", 0, 0, 0, 1, 1, 0, FWD_RTYPE, 31, 31, 0, 31, DEF, DEF);
        drv("loaduse_rn_stur", 0, 0, 0, 1, 1, 0, FWD_STUR, 7, 0, 0, 7, STL, STL);
        drv("itype_rm_unused", 0, 0, 0, 1, 1, 0, FWD_ITYPE, 1, 7, 0, 7, DEF, DEF);
        drv("none_unused", 0, 0, 0, 1, 1, 0, FWD_NONE, 7, 7, 0, 7, DEF, DEF);
        drv("alu_no_stall", 0, 0, 0, 0, 1, 0, FWD_RTYPE, 7, 7, 0, 7, DEF, DEF);

        // CBZ behind a load: two stall cycles, hazard and branch ignored in STALL.
        drv("cbz_ld_c1", 0, 0, 0, 1, 1, 1, FWD_NONE, 0, 0, 9, 9, STL, STL);
        drv("cbz_ld_c2", 0, 0, 1, 1, 1, 1, FWD_NONE, 0, 0, 9, 9, STL, STL);
        idle("cbz_ld_after", DEF, DEF);
        drv("cbz_alu", 0, 0, 0, 0, 1, 1, FWD_NONE, 0, 0, 9, 9, STL, STL);
        idle("cbz_alu_after", DEF, DEF);
        drv("cbz_no_regwrite", 0, 0, 0, 0, 0, 1, FWD_NONE, 0, 0, 9, 9, DEF, DEF);
        drv("cbz_xzr", 0, 0, 0, 1, 1, 1, FWD_NONE, 0, 0, 31, 31, DEF, DEF);

        // Branch flush, and stall taking priority over flush.
        drv("br_flush", 0, 0, 1, 0, 0, 0, FWD_NONE, 0, 0, 0, 0, FLU, FLU);
        idle("br_after", DEF, DEF);
        drv("br_vs_stall", 0, 0, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, STL, STL);
        idle("br_vs_stall_after", DEF, DEF);

        // Multiply with a load-use hazard and taken branch held throughout.
        drv("mul_c0", 0, 1, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, FRZ, FRZ);
        drv("mul_c1", 0, 0, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, FRZ, DEF);
        drv("mul_c2", 0, 0, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, FRZ, STL);
        drv("mul_c3", 0, 0, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, DEF, STL);
        drv("mul_c4", 0, 0, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, STL, STL);
        idle("mul_after", DEF, DEF);

        // Reset on the second freeze cycle aborts the multiply.
        drv("rstmul_c0", 0, 1, 0, 0, 0, 0, FWD_NONE, 0, 0, 0, 0, FRZ, FRZ);
        drv("rstmul_c1", 1, 0, 1, 1, 1, 0, FWD_RTYPE, 0, 5, 0, 5, DEF, DEF);
        idle("rstmul_c2", DEF, DEF);
        idle("rstmul_c3", DEF, DEF);

        repeat (2) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
